// File: rtl/frame_pixel_streamer_pkg.sv
// frame_pixel_streamer_pkg: shared pixel width, FSM states and pixel-framing struct
package frame_pixel_streamer_pkg;
  localparam int PIX_W = 8;
  typedef enum logic [1:0] {IDLE, READ, BLANK, DONE} state_t;
  typedef struct packed {
    logic [PIX_W-1:0] dout;
    logic             valid;
    logic             sof;
    logic             eol;
    logic             eof;
  } pix_t;
endpackage

// File: rtl/frame_pixel_streamer_if.sv
// frame_pixel_streamer_if: frame-memory read port plus framed pixel stream
// master: drives mem_rd/mem_addr and the pixel stream, samples mem_data
// slave:  memory + stream consumer side
interface frame_pixel_streamer_if #(parameter int ADDR_W = 21);
  import frame_pixel_streamer_pkg::*;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_data;
  logic [PIX_W-1:0]  dout;
  logic              dout_valid;
  logic              sof;
  logic              eol;
  logic              eof;
  logic [ADDR_W-1:0] cnt;
  modport master (output mem_rd, mem_addr, dout, dout_valid, sof, eol, eof, cnt, input mem_data);
  modport slave  (input mem_rd, mem_addr, dout, dout_valid, sof, eol, eof, cnt, output mem_data);
endinterface

// File: rtl/frame_pixel_streamer_raster_counter.sv
// raster_counter: raster address/column/row counters plus horizontal-blank counter
// clr restarts at pixel 0, inc advances one pixel, blank counts blanking cycles
// blank_done flags the final blanking cycle
module raster_counter #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int HBLANK = 0,
  parameter int ADDR_W = 21,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H),
  localparam int BW = HBLANK > 0 ? $clog2(HBLANK + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic              blank,
  output logic [ADDR_W-1:0] addr,
  output logic [CW-1:0]     col,
  output logic [RW-1:0]     row,
  output logic              last_in_row,
  output logic              last_in_frame,
  output logic              blank_done
);
  localparam logic [BW-1:0] BLK_LAST = BW'(HBLANK > 0 ? HBLANK - 1 : 0);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [BW-1:0]     blk_q, blk_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      blk_q  <= '0;
    end else begin
      addr_q <= addr_d;
      col_q  <= col_d;
      row_q  <= row_d;
      blk_q  <= blk_d;
    end
  end
  assign last_in_row   = col_q == CW'(IMG_W - 1);
  assign last_in_frame = last_in_row && row_q == RW'(IMG_H - 1);
  assign blank_done    = blk_q == BLK_LAST;
  // addr and row hold at the final pixel so nothing wraps inside a frame
  always_comb begin
    addr_d = clr ? '0 : (inc && !last_in_frame) ? addr_q + 1'b1 : addr_q;
    col_d  = clr ? '0 : inc ? (last_in_row ? '0 : col_q + 1'b1) : col_q;
    row_d  = clr ? '0 : (inc && last_in_row && !last_in_frame) ? row_q + 1'b1 : row_q;
    blk_d  = (blank && !blank_done) ? blk_q + 1'b1 : '0;
  end
  assign addr = addr_q;
  assign col  = col_q;
  assign row  = row_q;
endmodule

// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer: streams a stored frame from 1-cycle-latency memory as raster pixels
// clk/rst (sync, active-low), start request, busy/complete status,
// bus: memory read port and framed pixel stream (dout, dout_valid, sof, eol, eof, cnt)
module frame_pixel_streamer
  import frame_pixel_streamer_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int HBLANK = 0,
  parameter int ADDR_W = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic complete,
  frame_pixel_streamer_if.master bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  state_t            state_q, state_d;
  logic              valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic              complete_q, complete_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              last_in_row, last_in_frame, blank_done, rd, go;
  pix_t              pix;
  raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .HBLANK(HBLANK), .ADDR_W(ADDR_W)) u_cnt (
    .clk(clk), .rst(rst), .clr(go), .inc(rd), .blank(state_q == BLANK),
    .addr(addr), .col(col), .row(row),
    .last_in_row(last_in_row), .last_in_frame(last_in_frame), .blank_done(blank_done)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      cnt_q      <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      eof_q      <= eof_d;
      cnt_q      <= cnt_d;
      complete_q <= complete_d;
    end
  end
  assign rd = state_q == READ;
  // DONE still has the last pixel in the output stage for one cycle; start is ignored then
  assign go = start && (state_q == IDLE || state_q == DONE) && !valid_q;
  always_comb begin
    state_d = state_q;
    if (go)
      state_d = READ;
    else if (state_q == READ)
      state_d = last_in_frame ? DONE : (last_in_row && HBLANK > 0) ? BLANK : READ;
    else if (state_q == BLANK && blank_done)
      state_d = READ;
    valid_d    = rd;
    sof_d      = rd && row == '0 && col == '0;
    eol_d      = rd && last_in_row;
    eof_d      = rd && last_in_frame;
    cnt_d      = rd ? addr : '0;
    complete_d = go ? 1'b0 : eof_q ? 1'b1 : complete_q;
  end
  assign pix = '{dout: valid_q ? bus.mem_data : '0, valid: valid_q, sof: sof_q, eol: eol_q, eof: eof_q};
  assign bus.mem_rd     = rd;
  assign bus.mem_addr   = rd ? addr : '0;
  assign bus.dout       = pix.dout;
  assign bus.dout_valid = pix.valid;
  assign bus.sof        = pix.sof;
  assign bus.eol        = pix.eol;
  assign bus.eof        = pix.eof;
  assign bus.cnt        = cnt_q;
  assign busy           = rd || state_q == BLANK || valid_q;
  assign complete       = complete_q;
endmodule

// File: doc/frame_pixel_streamer.md
# frame_pixel_streamer

Streams a stored grayscale frame out of a synchronous-read frame memory as a raster-order 8-bit pixel stream, one pixel per clock. It carries row/column framing markers and a running pixel index. It is the transmit end of the pixel-stream interface consumed by the 11x11 window generator in the SIFT front end. It replaces free-running counter stimulus with real image data and gives deterministic frame boundaries.

## Interface
- IMG_W, 640, pixels per row (≥2)
- IMG_H, 480, rows per frame (≥2)
- HBLANK, 0, idle cycles inserted after each row (0 = back-to-back rows)
- ADDR_W, 21, memory address / pixel index width; IMG_W*IMG_H ≤ 2^ADDR_W
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low; clock clk
- start  in  1  one-cycle request to stream a frame; honoured only in IDLE or DONE
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address, raster order, row*IMG_W+col
- mem_data  in  8  read data, valid exactly 1 cycle after a cycle with mem_rd=1
- dout  out  8  pixel value
- dout_valid  out  1  dout carries a pixel this cycle
- sof  out  1  with first pixel of frame
- eol  out  1  with last pixel of each row
- eof  out  1  with last pixel of frame
- cnt  out  ADDR_W  index of the pixel on dout (0-based)
- busy  out  1  frame in progress (READ, BLANK, or pipeline draining)
- complete  out  1  frame fully emitted; held until next accepted start or reset

## Operation
- FSM states: IDLE, READ, BLANK, DONE.
- IDLE/DONE + start=1: go to READ. Clear col, row, and addr to 0. Clear complete.
- READ: mem_rd=1, mem_addr=addr. Each cycle, addr+1 and col+1.
  - At col=IMG_W-1: col→0, row+1.
  - If HBLANK>0 and not the last row: go to BLANK.
  - Last pixel (row=IMG_H-1, col=IMG_W-1): go to DONE.
- BLANK: mem_rd=0. Count HBLANK cycles, then return to READ.
- DONE: mem_rd=0. complete=1 once the final pixel has left dout.
- Output stage: one register stage tracks the read pipeline.
  - Every cycle with mem_rd=1 produces exactly one cycle with dout_valid=1, one cycle later.
  - dout=mem_data on that cycle.
  - cnt=address issued the previous cycle.
  - sof/eol/eof are computed at issue time and delayed with the data.
- When dout_valid=0: dout, cnt, sof, eol, and eof hold 0.
- start while busy=1 is ignored: no restart, no effect on counters.
- start in the same cycle the last read issues is ignored. start in DONE restarts.
- Width rules:
  - Counters never wrap inside a frame. addr saturates conceptually at IMG_W*IMG_H-1, and the FSM leaves READ there.
  - col is ⌈log2 IMG_W⌉ bits, row is ⌈log2 IMG_H⌉ bits, blank counter is ⌈log2(HBLANK+1)⌉ bits (min 1).

## Timing
- Reset (rst=0 at an edge): next cycle has state=IDLE. Every output is 0: mem_rd, mem_addr, dout, dout_valid, sof, eol, eof, cnt, busy, complete.
- Reset mid-frame aborts immediately. The in-flight read's data is discarded and no dout_valid follows.
- start accepted at edge T:
  - mem_rd=1, mem_addr=0 during cycle T+1.
  - dout_valid=1, sof=1, cnt=0 during cycle T+2.
- HBLANK=0: dout_valid is continuous for IMG_W*IMG_H cycles starting T+2.
- Frame length in cycles: IMG_W*IMG_H + (IMG_H-1)*HBLANK.
- eof and the last pixel occur in cycle T+1+IMG_W*IMG_H+(IMG_H-1)*HBLANK. complete rises the following cycle.
- busy rises at T+1. busy falls the same cycle complete rises.

## Structure
- Shared package constant: PIX_W=8.
- Shared package typedef: pixel-framing struct {dout, valid, sof, eol, eof}, also consumed by the window generator side.
- Single module. The raster address/row/col/blank counter block is a natural sub-module: raster_counter, parameterised by IMG_W, IMG_H, HBLANK, with outputs addr, col, row, last_in_row, last_in_frame.
- The memory is external. The bench uses a behavioural 1-cycle-latency ROM.

## Test plan
- Reset then idle, IMG_W=4, IMG_H=3: all outputs 0 for 20 cycles. start pulsed with rst=0 has no effect.
- IMG_W=4, IMG_H=3, HBLANK=0, ROM[i]=i+10:
  - dout = 10..21 on 12 consecutive cycles, starting 2 cycles after start.
  - sof at cnt=0; eol at cnt=3, 7, 11; eof at cnt=11.
  - complete rises 1 cycle after eof.
- HBLANK=2, same image: exactly 2 dout_valid=0 cycles after cnt=3 and after cnt=7, none after cnt=11. Total span is 16 cycles.
- start re-pulsed at cnt=5: stream unaffected. After complete, a new start replays 10..21 and complete drops at the accepting edge.
- rst=0 asserted while cnt=6 is on dout: next cycle all outputs 0 and no further dout_valid. A fresh start restarts at cnt=0.
- Default 640x480, ROM[i]=i mod 201: 307200 pixels in order. Last cnt=307199, eof single-cycle, no gaps.
